// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, fetch FSM state encoding, decode helpers.
package cpu_pkg;

    localparam int unsigned OPC_W    = 4;
    localparam int unsigned OPND_W   = 4;
    localparam int unsigned RETIRE_W = 16;

    // Assigned opcodes; 4'h9 and 4'hE are intentionally left unassigned.
    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h6;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h7;
    localparam logic [OPC_W-1:0] OP_BRZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_LD   = 4'hA;
    localparam logic [OPC_W-1:0] OP_ST   = 4'hB;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'hC;
    localparam logic [OPC_W-1:0] OP_JR   = 4'hD;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXEC    = 2'd2,
        ST_HALTED  = 2'd3
    } fetch_state_e;

    // True for the opcode slots that have no instruction behind them.
    function automatic logic is_illegal_op(input logic [OPC_W-1:0] op);
        return (op == 4'b1001) || (op == 4'b1110);
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: jump target (PC + offset), PC + 1, or hold. Purely combinational.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic [PC_W-1:0]   PC,
    input  logic [PC_W-1:0]   RegData,
    input  logic [OPND_W-1:0] Operand,
    input  logic              SelPC,
    input  logic              LoadPC,
    input  logic              IncPC,
    output logic [PC_W-1:0]   NextPC
);

    logic [PC_W-1:0] offset_c;

    // Jump wins over increment; all sums wrap modulo 2^PC_W.
    always_comb begin
        offset_c = SelPC ? {{(PC_W-OPND_W){Operand[OPND_W-1]}}, Operand} : RegData;
        NextPC   = PC;
        if (LoadPC) begin
            NextPC = PC + offset_c;
        end else if (IncPC) begin
            NextPC = PC + PC_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: FETCH/DECODE/EXEC/HALTED sequencing, PC and IR ownership.
// Optional retired-instruction counter enabled by macro INSTR_FETCH_RETIRE_CNT_EN.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 8,
    parameter int unsigned IR_W = 8
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                LoadIR,
    input  logic                IncPC,
    input  logic                SelPC,
    input  logic                LoadPC,
    input  logic [PC_W-1:0]     RegData,
    input  logic [IR_W-1:0]     ImemRdata,
    input  logic                ImemValid,
    output logic                ImemReq,
    output logic [PC_W-1:0]     ImemAddr,
    output logic [OPC_W-1:0]    Opcode,
    output logic [OPND_W-1:0]   Operand,
    output logic [PC_W-1:0]     PC,
    output logic                Halted,
    output logic                IllegalOp,
    output logic [RETIRE_W-1:0] RetiredCount
);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [IR_W-1:0] ir_q;
    logic            req_q;
    logic            halted_q;
    logic            illegal_q;

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_pc_next_calc (
        .PC      (pc_q),
        .RegData (RegData),
        .Operand (ir_q[3:0]),
        .SelPC   (SelPC),
        .LoadPC  (LoadPC),
        .IncPC   (IncPC),
        .NextPC  (pc_d)
    );

    // Fetch sequencer; ImemReq/Halted are registered alongside the state they reflect.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            req_q     <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // First cycle out of reset raises the request; valid only counts while requesting.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (ImemValid) begin
                        ir_q    <= ImemRdata;
                        req_q   <= 1'b0;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_illegal_op(ir_q[7:4])) begin
                        illegal_q <= 1'b1;
                        halted_q  <= 1'b1;
                        state_q   <= ST_HALTED;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    pc_q <= pc_d;
                    if (LoadIR) begin
                        req_q   <= 1'b1;
                        state_q <= ST_FETCH;
                    end else begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef INSTR_FETCH_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] retired_q;

    // Saturating count of EXEC cycles since reset.
    always_ff @(posedge Clk) begin
        if (reset) begin
            retired_q <= '0;
        end else if ((state_q == ST_EXEC) && (retired_q != {RETIRE_W{1'b1}})) begin
            retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    assign RetiredCount = retired_q;
`else
    assign RetiredCount = '0;
`endif

    assign ImemReq   = req_q;
    assign ImemAddr  = pc_q;
    assign PC        = pc_q;
    assign Opcode    = ir_q[7:4];
    assign Operand   = ir_q[3:0];
    assign Halted    = halted_q;
    assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: acts as instruction memory and controller,
// randomizes wait states and controls, and predicts PC/IR/flags with a behavioural model.
module tb_instr_fetch_unit;

    logic        Clk;
    logic        reset;
    logic        LoadIR;
    logic        IncPC;
    logic        SelPC;
    logic        LoadPC;
    logic [7:0]  RegData;
    logic [7:0]  ImemRdata;
    logic        ImemValid;
    logic        ImemReq;
    logic [7:0]  ImemAddr;
    logic [3:0]  Opcode;
    logic [3:0]  Operand;
    logic [7:0]  PC;
    logic        Halted;
    logic        IllegalOp;
    logic [15:0] RetiredCount;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    logic [7:0] m_pc;
    int         m_retired;

    // Observations from the last run_instr call
    bit         last_fetch_ok;
    logic [7:0] last_addr;
    logic [7:0] last_dec_ir;
    int         last_entry;

    instr_fetch_unit dut (
        .Clk          (Clk),
        .reset        (reset),
        .LoadIR       (LoadIR),
        .IncPC        (IncPC),
        .SelPC        (SelPC),
        .LoadPC       (LoadPC),
        .RegData      (RegData),
        .ImemRdata    (ImemRdata),
        .ImemValid    (ImemValid),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .Opcode       (Opcode),
        .Operand      (Operand),
        .PC           (PC),
        .Halted       (Halted),
        .IllegalOp    (IllegalOp),
        .RetiredCount (RetiredCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Next PC from the written rules, using signed integer offsets.
    function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [3:0] opnd,
                                              input logic [7:0] rd, input bit sel,
                                              input bit ld, input bit inc);
        int off;
        off = sel ? ((int'(opnd) >= 8) ? int'(opnd) - 16 : int'(opnd)) : int'(rd);
        if (ld)  return 8'((int'(pc) + off + 256) % 256);
        if (inc) return 8'((int'(pc) + 1) % 256);
        return pc;
    endfunction

    function automatic bit model_illegal(input logic [7:0] instr);
        return (instr[7:4] == 4'd9) || (instr[7:4] == 4'd14);
    endfunction

    function automatic logic [15:0] exp_retired();
`ifdef INSTR_FETCH_RETIRE_CNT_EN
        return (m_retired > 65535) ? 16'hFFFF : 16'(m_retired);
`else
        return 16'h0000;
`endif
    endfunction

    // Garbage on controller inputs; these must only matter in EXEC.
    task automatic scramble_ctrl();
        LoadIR  = 1'($urandom);
        IncPC   = 1'($urandom);
        SelPC   = 1'($urandom);
        LoadPC  = 1'($urandom);
        RegData = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        reset     = 1'b1;
        ImemValid = 1'b1;
        ImemRdata = 8'($urandom);
        scramble_ctrl();
        @(negedge Clk);
        @(negedge Clk);
        reset     = 1'b0;
        ImemValid = 1'b0;
        m_pc      = 8'h00;
        m_retired = 0;
    endtask

    // One instruction as memory + controller: fetch with waits, decode, exec. Updates the model.
    task automatic run_instr(input int waits, input logic [7:0] instr, input bit ldir,
                             input bit inc, input bit ld, input bit sel, input logic [7:0] rd);
        logic [7:0] ir_before;
        int n;
        last_fetch_ok = 1'b1;
        n = 0;
        scramble_ctrl();
        while (ImemReq !== 1'b1 && n < 20) begin
            @(negedge Clk);
            scramble_ctrl();
            n++;
        end
        if (ImemReq !== 1'b1) last_fetch_ok = 1'b0;
        last_entry = cyc;
        last_addr  = ImemAddr;
        ir_before  = {Opcode, Operand};
        for (int i = 0; i < waits; i++) begin
            ImemValid = 1'b0;
            ImemRdata = 8'($urandom);
            @(negedge Clk);
            scramble_ctrl();
            if (ImemReq !== 1'b1 || ImemAddr !== last_addr || {Opcode, Operand} !== ir_before)
                last_fetch_ok = 1'b0;
        end
        ImemValid = 1'b1;
        ImemRdata = instr;
        @(negedge Clk);
        ImemValid   = 1'b0;
        ImemRdata   = 8'($urandom);
        scramble_ctrl();
        last_dec_ir = {Opcode, Operand};
        if (model_illegal(instr)) begin
            @(negedge Clk);
            scramble_ctrl();
            return;
        end
        @(negedge Clk);
        LoadIR  = ldir;
        IncPC   = inc;
        LoadPC  = ld;
        SelPC   = sel;
        RegData = rd;
        @(negedge Clk);
        scramble_ctrl();
        m_pc = model_next(m_pc, instr[3:0], rd, sel, ld, inc);
        m_retired++;
    endtask

    task automatic goto_pc(input logic [7:0] t);
        run_instr(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'(t - m_pc));
    endtask

    task automatic test_reset();
        @(negedge Clk);
        reset     = 1'b1;
        ImemValid = 1'b1;
        ImemRdata = 8'hA5;
        scramble_ctrl();
        @(negedge Clk);
        @(negedge Clk);
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", ImemReq); end
        checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", Halted); end
        checks++; if (Opcode !== 4'h0) begin errors++; $display("FAIL reset_opcode: got %h expected 0", Opcode); end
        checks++; if (Operand !== 4'h0) begin errors++; $display("FAIL reset_operand: got %h expected 0", Operand); end
        checks++; if (PC !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", PC); end
        checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", IllegalOp); end
        checks++; if (RetiredCount !== 16'h0) begin errors++; $display("FAIL reset_retired: got %h expected 0", RetiredCount); end
        reset     = 1'b0;
        m_pc      = 8'h00;
        m_retired = 0;
        // Valid while no request is outstanding must be ignored.
        ImemValid = 1'b1;
        ImemRdata = 8'h3C;
        @(negedge Clk);
        ImemValid = 1'b0;
        checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL req_after_reset: got %b expected 1", ImemReq); end
        checks++; if (ImemAddr !== 8'h00) begin errors++; $display("FAIL addr_after_reset: got %h expected 00", ImemAddr); end
        checks++; if ({Opcode, Operand} !== 8'h00) begin errors++; $display("FAIL valid_without_req: got %h expected 00", {Opcode, Operand}); end
    endtask

    task automatic test_nop_stream();
        int prev_entry;
        do_reset();
        prev_entry = 0;
        for (int k = 0; k < 4; k++) begin
            run_instr(0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            checks++; if (last_addr !== 8'(k)) begin errors++; $display("FAIL nop_fetch_pc[%0d]: got %h expected %h", k, last_addr, 8'(k)); end
            if (k > 0) begin
                checks++; if (last_entry - prev_entry != 3) begin errors++; $display("FAIL nop_latency[%0d]: got %0d expected 3", k, last_entry - prev_entry); end
            end
            prev_entry = last_entry;
        end
        checks++; if (PC !== m_pc) begin errors++; $display("FAIL nop_pc: got %h expected %h", PC, m_pc); end
    endtask

    task automatic test_wait_states();
        goto_pc(8'h05);
        run_instr(4, 8'h35, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (last_fetch_ok !== 1'b1) begin errors++; $display("FAIL wait_hold: got %b expected 1", last_fetch_ok); end
        checks++; if (last_addr !== 8'h05) begin errors++; $display("FAIL wait_addr: got %h expected 05", last_addr); end
        checks++; if (last_dec_ir !== 8'h35) begin errors++; $display("FAIL wait_ir: got %h expected 35", last_dec_ir); end
        checks++; if (PC !== 8'h06) begin errors++; $display("FAIL wait_pc: got %h expected 06", PC); end
    endtask

    task automatic test_jumps();
        goto_pc(8'h10);
        run_instr(0, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 8'($urandom));
        checks++; if (PC !== 8'h0E) begin errors++; $display("FAIL jump_sext: got %h expected 0e", PC); end
        goto_pc(8'hF0);
        run_instr(0, 8'h73, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20);
        checks++; if (PC !== 8'h10) begin errors++; $display("FAIL jump_regdata: got %h expected 10", PC); end
        goto_pc(8'hFF);
        run_instr(0, 8'h10, 1'b1, 1'b1, 1'b0, 1'($urandom), 8'($urandom));
        checks++; if (PC !== 8'h00) begin errors++; $display("FAIL inc_wrap: got %h expected 00", PC); end
        run_instr(0, 8'h20, 1'b1, 1'b0, 1'b0, 1'($urandom), 8'($urandom));
        checks++; if (PC !== 8'h00) begin errors++; $display("FAIL pc_hold: got %h expected 00", PC); end
    endtask

    task automatic test_random();
        logic [7:0] instr;
        logic [7:0] pc_before;
        int w;
        for (int k = 0; k < 60; k++) begin
            instr = 8'($urandom);
            if (model_illegal(instr)) instr[7:4] = 4'h0;
            w = $urandom_range(0, 3);
            pc_before = m_pc;
            run_instr(w, instr, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            checks++; if (last_fetch_ok !== 1'b1 || last_addr !== pc_before) begin errors++; $display("FAIL rnd_fetch[%0d]: ok=%b addr=%h expected addr=%h", k, last_fetch_ok, last_addr, pc_before); end
            checks++; if (last_dec_ir !== instr) begin errors++; $display("FAIL rnd_ir[%0d]: got %h expected %h", k, last_dec_ir, instr); end
            checks++; if (PC !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", k, PC, m_pc); end
            checks++; if (RetiredCount !== exp_retired() || IllegalOp !== 1'b0 || Halted !== 1'b0) begin errors++; $display("FAIL rnd_status[%0d]: retired=%h ill=%b halt=%b expected retired=%h ill=0 halt=0", k, RetiredCount, IllegalOp, Halted, exp_retired()); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        goto_pc(8'h07);
        run_instr(0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'($urandom), 8'($urandom));
        for (int k = 0; k < 20; k++) begin
            checks++; if (Halted !== 1'b1 || PC !== 8'h07 || ImemReq !== 1'b0) begin errors++; $display("FAIL halt_hold[%0d]: halted=%b pc=%h req=%b expected 1 07 0", k, Halted, PC, ImemReq); end
            ImemValid = 1'($urandom);
            ImemRdata = 8'($urandom);
            scramble_ctrl();
            @(negedge Clk);
        end
        ImemValid = 1'b0;
        checks++; if ({Opcode, Operand} !== 8'hF0 || RetiredCount !== exp_retired()) begin errors++; $display("FAIL halt_ir: ir=%h retired=%h expected f0 %h", {Opcode, Operand}, RetiredCount, exp_retired()); end
        do_reset();
        @(negedge Clk);
        checks++; if (ImemReq !== 1'b1 || PC !== 8'h00 || Halted !== 1'b0) begin errors++; $display("FAIL halt_restart: req=%b pc=%h halted=%b expected 1 00 0", ImemReq, PC, Halted); end
    endtask

    task automatic test_midfetch_reset();
        do_reset();
        run_instr(0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        reset     = 1'b1;
        ImemValid = 1'b1;
        ImemRdata = 8'h5A;
        @(negedge Clk);
        checks++; if ({Opcode, Operand} !== 8'h00 || ImemReq !== 1'b0 || PC !== 8'h00) begin errors++; $display("FAIL midfetch_reset: ir=%h req=%b pc=%h expected 00 0 00", {Opcode, Operand}, ImemReq, PC); end
        reset     = 1'b0;
        ImemValid = 1'b0;
        m_pc      = 8'h00;
        m_retired = 0;
        @(negedge Clk);
        checks++; if (ImemReq !== 1'b1 || {Opcode, Operand} !== 8'h00) begin errors++; $display("FAIL midfetch_restart: req=%b ir=%h expected 1 00", ImemReq, {Opcode, Operand}); end
    endtask

    task automatic test_illegal();
        do_reset();
        run_instr(0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        run_instr(1, 8'h93, 1'b1, 1'b1, 1'b1, 1'b0, 8'h40);
        checks++; if (IllegalOp !== 1'b1 || Halted !== 1'b1) begin errors++; $display("FAIL illegal_9: ill=%b halted=%b expected 1 1", IllegalOp, Halted); end
        checks++; if (PC !== m_pc || ImemReq !== 1'b0) begin errors++; $display("FAIL illegal_9_pc: pc=%h req=%b expected %h 0", PC, ImemReq, m_pc); end
        checks++; if (RetiredCount !== exp_retired()) begin errors++; $display("FAIL illegal_retired: got %h expected %h", RetiredCount, exp_retired()); end
        repeat (5) begin
            ImemValid = 1'($urandom);
            scramble_ctrl();
            @(negedge Clk);
        end
        ImemValid = 1'b0;
        checks++; if (IllegalOp !== 1'b1 || PC !== m_pc) begin errors++; $display("FAIL illegal_sticky: ill=%b pc=%h expected 1 %h", IllegalOp, PC, m_pc); end
        do_reset();
        checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b expected 0", IllegalOp); end
        run_instr(0, 8'hE7, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (IllegalOp !== 1'b1 || Halted !== 1'b1 || PC !== 8'h00) begin errors++; $display("FAIL illegal_e: ill=%b halted=%b pc=%h expected 1 1 00", IllegalOp, Halted, PC); end
    endtask

    task automatic test_retire();
        logic [15:0] want;
        do_reset();
        for (int k = 0; k < 5; k++)
            run_instr($urandom_range(0, 2), 8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        run_instr(0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef INSTR_FETCH_RETIRE_CNT_EN
        want = 16'd6;
`else
        want = 16'd0;
`endif
        checks++; if (RetiredCount !== want || Halted !== 1'b1) begin errors++; $display("FAIL retire_count: got %h halted=%b expected %h 1", RetiredCount, Halted, want); end
        checks++; if (PC !== 8'h05) begin errors++; $display("FAIL retire_pc: got %h expected 05", PC); end
    endtask

    initial begin
        reset     = 1'b1;
        LoadIR    = 1'b0;
        IncPC     = 1'b0;
        SelPC     = 1'b0;
        LoadPC    = 1'b0;
        RegData   = 8'h00;
        ImemRdata = 8'h00;
        ImemValid = 1'b0;
        m_pc      = 8'h00;
        m_retired = 0;
        test_reset();
        test_nop_stream();
        test_wait_states();
        test_jumps();
        test_random();
        test_halt();
        test_midfetch_reset();
        test_illegal();
        test_retire();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
- REQ-001 SHALL have parameter PC_W, default 8: program counter and instruction-memory address width.
- REQ-002 SHALL have parameter IR_W, default 8: instruction width, with opcode in [7:4] and operand in [3:0].
- REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005 SHALL have port LoadIR, input, 1 bit: from the controller; fetch the next instruction.
- REQ-006 SHALL have port IncPC, input, 1 bit: from the controller; PC <= PC+1.
- REQ-007 SHALL have port SelPC, input, 1 bit: jump offset select; 0 = RegData, 1 = sign-extended operand.
- REQ-008 SHALL have port LoadPC, input, 1 bit: from the controller; PC <= jump target.
- REQ-009 SHALL have port RegData, input, PC_W bits: register-file read value used as the jump offset.
- REQ-010 SHALL have port ImemRdata, input, IR_W bits: instruction-memory read data.
- REQ-011 SHALL have port ImemValid, input, 1 bit: ImemRdata valid for the outstanding request.
- REQ-012 SHALL have port ImemReq, output, 1 bit: instruction-memory read request.
- REQ-013 SHALL have port ImemAddr, output, PC_W bits: equal to PC.
- REQ-014 SHALL have port Opcode, output, 4 bits: IR[7:4], driven to the controller.
- REQ-015 SHALL have port Operand, output, 4 bits: IR[3:0].
- REQ-016 SHALL have port PC, output, PC_W bits: current program counter.
- REQ-017 SHALL have port Halted, output, 1 bit: HALTED state indicator.
- REQ-018 SHALL have port IllegalOp, output, 1 bit: sticky flag for an unassigned opcode.
- REQ-019 SHALL have port RetiredCount, output, 16 bits: see Configuration.

Function
- REQ-020 SHALL implement a four-state FSM: FETCH, DECODE, EXEC, HALTED.
- REQ-021 In FETCH, the block SHALL drive ImemReq=1 with ImemAddr=PC, holding both stable until ImemValid=1.
- REQ-022 On ImemValid=1 in FETCH, the block SHALL capture IR<=ImemRdata and go to DECODE; wait states are unbounded.
- REQ-023 ImemValid SHALL be ignored whenever ImemReq=0.
- REQ-024 DECODE SHALL last exactly one cycle, giving the registered controller one edge to produce controls; it then goes to EXEC.
- REQ-025 In DECODE, opcode 4'b1001 or 4'b1110 SHALL set IllegalOp=1 and go to HALTED; EXEC is skipped and PC is unchanged.
- REQ-026 In EXEC, if LoadPC=1, PC SHALL load the jump target: PC + RegData when SelPC=0, PC + sign-extended Operand when SelPC=1; otherwise, if IncPC=1, PC SHALL load PC+1; otherwise PC SHALL hold.
- REQ-027 LoadPC SHALL take priority over IncPC when both are 1.
- REQ-028 PC arithmetic SHALL be modulo 2^PC_W: 8'hFF+1 = 8'h00, and negative offsets wrap.
- REQ-029 In EXEC, LoadIR=1 SHALL go to FETCH; LoadIR=0 SHALL go to HALTED. Controller HALT arrives as LoadIR=0, IncPC=0, LoadPC=0.
- REQ-030 HALTED SHALL be terminal until reset, with ImemReq=0, PC and IR held, and Halted=1.
- REQ-031 Fetch-to-fetch latency SHALL be 3 cycles with zero-wait memory: FETCH, DECODE, EXEC.
- REQ-032 Control inputs SHALL be ignored outside EXEC.

Reset
- REQ-033 While reset=1 on a rising edge, the block SHALL set state=FETCH, PC=0, IR=8'h00 (NOP), IllegalOp=0, and RetiredCount=0.
- REQ-034 Outputs during the reset cycle SHALL be: ImemReq=0, Halted=0, Opcode=0, Operand=0.
- REQ-035 ImemReq SHALL first assert in the cycle after reset deasserts.
- REQ-036 Reset mid-fetch or in HALTED SHALL abandon the request; an ImemValid in the reset cycle SHALL be discarded.

Configuration
- REQ-037 With macro INSTR_FETCH_RETIRE_CNT_EN defined, RetiredCount SHALL increment by 1 on each EXEC cycle, saturating at 16'hFFFF.
- REQ-038 Without INSTR_FETCH_RETIRE_CNT_EN, RetiredCount SHALL be constant 0 and no counter flops SHALL exist.

Structure
- REQ-039 Opcode constants (ADD..HALT) and the FSM state encoding SHALL live in shared package cpu_pkg, which the controller also uses.
- REQ-040 The target/increment mux SHALL be sub-module pc_next_calc: combinational, with inputs PC, RegData, Operand, SelPC, LoadPC, IncPC and output next PC.

Verification
- REQ-041 Scenario: reset, then a zero-wait NOP stream -> PC reads 0,1,2 at successive FETCH entries, 3 cycles apart.
- REQ-042 Scenario: ImemValid delayed 4 cycles at PC=5 -> ImemReq=1 and ImemAddr=5 held stable for 4 cycles, IR captured on the fifth.
- REQ-043 Scenario: at PC=8'h10, Operand=4'hE, LoadPC=1, SelPC=1 -> PC=8'h0E. At PC=8'hF0, RegData=8'h20, SelPC=0 -> PC=8'h10.
- REQ-044 Scenario: LoadIR=0, IncPC=0, LoadPC=0 in EXEC at PC=7 -> Halted=1, PC=7 and ImemReq=0 for 20 cycles; reset then restarts at PC=0.
- REQ-045 Scenario: fetch opcode 4'b1001 -> IllegalOp=1 and Halted=1 one cycle after DECODE, PC unchanged.
- REQ-046 Scenario: with INSTR_FETCH_RETIRE_CNT_EN, 5 executed instructions then HALT -> RetiredCount=6.
